// File: rtl/swc_multiport_page_allocator.sv
// swc_multiport_page_allocator: round-robin multi-port page allocator with per-page use counts
// Ports: clk_i/rst_n_i (async active-low); per-port alloc_i/free_i/force_free_i/set_usecnt_i
// requests with pg_addr_i/usecnt_i slices; done_o one-cycle completion pulse per port;
// pg_addr_alloc_o, free_last_usecnt_o, error_o valid with done_o; nomem_o, free_count_o status.
module swc_multiport_page_allocator #(
    parameter int g_num_ports       = 4,
    parameter int g_page_addr_width = 10,
    parameter int g_num_pages       = 1024,
    parameter int g_usecnt_width    = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic [g_num_ports-1:0]                       alloc_i,
    input  logic [g_num_ports-1:0]                       free_i,
    input  logic [g_num_ports-1:0]                       force_free_i,
    input  logic [g_num_ports-1:0]                       set_usecnt_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]     pg_addr_i,
    input  logic [g_num_ports*g_usecnt_width-1:0]        usecnt_i,
    output logic [g_num_ports-1:0]                       done_o,
    output logic [g_page_addr_width-1:0]                 pg_addr_alloc_o,
    output logic                                         free_last_usecnt_o,
    output logic                                         error_o,
    output logic                                         nomem_o,
    output logic [g_page_addr_width:0]                   free_count_o
);
    localparam int PW = g_page_addr_width;
    localparam int CW = g_usecnt_width;
    localparam int NW = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;

    typedef enum logic {IDLE, SERVE} state_e;
    typedef enum logic [1:0] {OP_ALLOC, OP_FREE, OP_FFREE, OP_SET} op_e;

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [NW-1:0]          port_q, port_d, rr_q, rr_d;
    logic [PW-1:0]          addr_q, addr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [g_num_ports-1:0] done_q, done_d;
    logic [PW-1:0]          pg_alloc_q, pg_alloc_d;
    logic                   free_last_q, free_last_d;
    logic                   error_q, error_d;
    logic                   nomem_q, nomem_d;
    logic [PW:0]            free_count_q, free_count_d;
    logic                   used_q [g_num_pages];
    logic [CW-1:0]          usecnt_q [g_num_pages];

    logic                   wr_en, wr_used;
    logic [PW-1:0]          wr_idx;
    logic [CW-1:0]          wr_cnt;
    logic [g_num_ports-1:0] elig;
    logic                   gnt_vld;
    logic [NW-1:0]          gnt;
    int                     rr_idx;
    logic [PW-1:0]          free_idx;
    logic                   in_range, pg_used;
    logic [CW-1:0]          pg_cnt;

    // Lowest-numbered free page; scanned downward so the last hit wins.
    always_comb begin
        free_idx = '0;
        for (int i = g_num_pages - 1; i >= 0; i--)
            if (!used_q[i]) free_idx = PW'(i);
    end

    // An alloc-only request cannot make progress while memory is exhausted.
    always_comb begin
        for (int p = 0; p < g_num_ports; p++)
            elig[p] = (alloc_i[p] | free_i[p] | force_free_i[p] | set_usecnt_i[p]) && !done_q[p] &&
                      !(nomem_q && !(free_i[p] | force_free_i[p] | set_usecnt_i[p]));
    end

    // rr_q holds the first port to consider: the one after the last grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = rr_q;
        rr_idx  = 0;
        for (int i = 0; i < g_num_ports; i++) begin
            rr_idx = int'(rr_q) + i;
            if (rr_idx >= g_num_ports) rr_idx = rr_idx - g_num_ports;
            if (!gnt_vld && elig[rr_idx]) begin
                gnt_vld = 1'b1;
                gnt     = NW'(rr_idx);
            end
        end
    end

    always_comb begin
        in_range = {1'b0, addr_q} < (PW+1)'(g_num_pages);
        pg_used  = in_range && used_q[addr_q];
        pg_cnt   = in_range ? usecnt_q[addr_q] : '0;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        port_d       = port_q;
        rr_d         = rr_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        done_d       = '0;
        pg_alloc_d   = '0;
        free_last_d  = 1'b0;
        error_d      = 1'b0;
        free_count_d = free_count_q;
        wr_en        = 1'b0;
        wr_used      = 1'b0;
        wr_idx       = addr_q;
        wr_cnt       = '0;
        if (state_q == IDLE) begin
            if (gnt_vld) begin
                state_d = SERVE;
                port_d  = gnt;
                rr_d    = (gnt == NW'(g_num_ports - 1)) ? '0 : gnt + 1'b1;
                op_d    = force_free_i[gnt] ? OP_FFREE : free_i[gnt] ? OP_FREE :
                          set_usecnt_i[gnt] ? OP_SET : OP_ALLOC;
                addr_d  = pg_addr_i[gnt*PW +: PW];
                cnt_d   = usecnt_i[gnt*CW +: CW];
            end
        end else begin
            state_d         = IDLE;
            done_d[port_q]  = 1'b1;
            if (op_q == OP_ALLOC) begin
                if (free_count_q != '0) begin
                    wr_en        = 1'b1;
                    wr_used      = 1'b1;
                    wr_idx       = free_idx;
                    wr_cnt       = cnt_q;
                    pg_alloc_d   = free_idx;
                    free_count_d = free_count_q - 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end else if (!pg_used || (op_q == OP_SET && cnt_q == '0)) begin
                error_d = 1'b1;
            end else if (op_q == OP_SET) begin
                wr_en   = 1'b1;
                wr_used = 1'b1;
                wr_cnt  = cnt_q;
            end else if (op_q == OP_FREE && pg_cnt > CW'(1)) begin
                wr_en   = 1'b1;
                wr_used = 1'b1;
                wr_cnt  = pg_cnt - 1'b1;
            end else begin
                wr_en        = 1'b1;
                free_last_d  = 1'b1;
                free_count_d = free_count_q + 1'b1;
            end
        end
        nomem_d = (free_count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            op_q         <= OP_ALLOC;
            port_q       <= '0;
            rr_q         <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            done_q       <= '0;
            pg_alloc_q   <= '0;
            free_last_q  <= 1'b0;
            error_q      <= 1'b0;
            nomem_q      <= 1'b0;
            free_count_q <= (PW+1)'(g_num_pages);
            for (int i = 0; i < g_num_pages; i++) begin
                used_q[i]   <= 1'b0;
                usecnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            port_q       <= port_d;
            rr_q         <= rr_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            pg_alloc_q   <= pg_alloc_d;
            free_last_q  <= free_last_d;
            error_q      <= error_d;
            nomem_q      <= nomem_d;
            free_count_q <= free_count_d;
            if (wr_en) begin
                used_q[wr_idx]   <= wr_used;
                usecnt_q[wr_idx] <= wr_cnt;
            end
        end
    end

    assign done_o             = done_q;
    assign pg_addr_alloc_o    = pg_alloc_q;
    assign free_last_usecnt_o = free_last_q;
    assign error_o            = error_q;
    assign nomem_o            = nomem_q;
    assign free_count_o       = free_count_q;
endmodule
